// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: evaluates SLICE bits per cycle, LSB first, with valid/ready on both sides.
// Define LOGIC_UNIT_FLAGS_EN to build the zero/negative result flags; otherwise they are tied low.
module logic_unit_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if (WIDTH % SLICE != 0) begin : g_bad_slice
    $error("logic_unit_seq: WIDTH must be a multiple of SLICE");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             capture, step, last;
  logic [SLICE-1:0] a_s, b_s, r_s;

  // Operand slice selected by the counter; only one narrow gate slice is built.
  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (cnt == CW'(i)) begin
        a_s = a_q[i*SLICE +: SLICE];
        b_s = b_q[i*SLICE +: SLICE];
      end
    end
  end

  always_comb begin
    case (op_q)
      3'b001:  r_s = a_s & b_s;
      3'b010:  r_s = a_s | b_s;
      3'b011:  r_s = a_s ^ b_s;
      3'b100:  r_s = ~(a_s & b_s);
      3'b101:  r_s = ~(a_s | b_s);
      3'b110:  r_s = ~(a_s ^ b_s);
      3'b111:  r_s = ~a_s;
      default: r_s = '0;
    endcase
  end

  assign last = (cnt == CW'(NSLICE - 1));

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    capture    = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          capture    = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (capture) begin
      a_q      <= a;
      b_q      <= b;
      op_q     <= op;
      cnt      <= '0;
      result_q <= '0;
    end else if (step) begin
      for (int i = 0; i < NSLICE; i++) begin
        if (cnt == CW'(i)) result_q[i*SLICE +: SLICE] <= r_s;
      end
      cnt <= cnt + CW'(1);
    end
  end

  assign result = result_q;

`ifdef LOGIC_UNIT_FLAGS_EN
  assign zero     = (result_q == '0);
  assign negative = result_q[WIDTH-1];
`else
  assign zero     = 1'b0;
  assign negative = 1'b0;
`endif

endmodule
